// File: rtl/psec5_spi_pkg.sv
// Shared types and constants for the SPI configuration master.
//   state_e     : controller FSM state encoding
//   NUM_CH      : number of addressable channel registers
//   FRAME_BITS  : serial frame length ({addr, wdata})
//   ADDR_W      : request address width
//   DATA_W      : request data width
//   addr_legal(): true when an address targets an existing channel
package psec5_spi_pkg;

  localparam int NUM_CH     = 8;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NUM_CH);
  endfunction

endpackage

// File: rtl/spi_cfg_master_if.sv
// Request/response bus between a register-access requester and
// spi_cfg_master.
//   req_valid/req_ready : request handshake, accepted when both high on a clock edge
//   req_addr/req_wdata  : channel register address and write value
//   done/err/rdata      : completion pulse, illegal-address flag, read-back byte
//   busy                : block is working on an accepted request
// Modports: master = requester side, slave = spi_cfg_master side.
interface spi_cfg_master_if
  import psec5_spi_pkg::*;
();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_wdata,
    input  req_ready, done, err, rdata, busy
  );

  modport slave (
    input  req_valid, req_addr, req_wdata,
    output req_ready, done, err, rdata, busy
  );

endinterface

// File: rtl/spi_clk_div.sv
// Serial clock generator for spi_cfg_master.
//   iclk, rstn : system clock, async active-low reset
//   en_i       : run the divider; when low sclk is parked low and the
//                phase counter reloads so a new frame starts with a full
//                low half-period
//   sclk_o     : serial clock, CLK_DIV iclk cycles per half-period
//   rise_o     : high in the cycle whose closing edge raises sclk
//   fall_o     : high in the cycle whose closing edge drops sclk
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic iclk,
  input  logic rstn,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       tc;

  assign tc = (cnt_q == 8'd0);

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = DIV_LOAD;
      phase_d = 1'b0;
    end else if (tc) begin
      cnt_d   = DIV_LOAD;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= DIV_LOAD;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign sclk_o = phase_q;
  assign rise_o = en_i & tc & ~phase_q;
  assign fall_o = en_i & tc & phase_q;

endmodule

// File: rtl/spi_cfg_master.sv
// SPI configuration master: accepts one register write at a time and
// serialises {addr, wdata} MSB first to an SPI slave, then idles sclk for
// GAP_CYC cycles before signalling completion. Addresses >= NUM_CH are
// rejected without any serial activity.
//   iclk, rstn   : system clock, async active-low reset
//   bus (slave)  : request handshake, done/err/rdata/busy
//   sclk         : serial clock, idles low
//   serial_in    : data to the slave, changes at the start of each bit
//   serial_out   : data from the slave, sampled as sclk rises
// Build option: SPI_READBACK_EN adds the serial_out sampler and drives
// rdata with the last 8 bits received; otherwise rdata is tied to zero.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for a request, req_ready high once out of reset
// ST_SHIFT | 16 sclk bit periods in flight
// ST_GAP   | sclk idle low, serial_in low, GAP_CYC cycles
// ST_DONE  | single-cycle done pulse (err set for a rejected address)
module spi_cfg_master
  import psec5_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 8
) (
  input  logic            iclk,
  input  logic            rstn,
  spi_cfg_master_if.slave bus,
  output logic            sclk,
  output logic            serial_in,
  input  logic            serial_out
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  err_q, err_d;
  logic                  rdy_q;
  logic                  accept, legal, sclk_rise, sclk_fall;
  logic                  req_ready, done, err, busy;

  assign legal  = addr_legal(bus.req_addr);
  assign accept = bus.req_valid && req_ready;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .iclk   (iclk),
    .rstn   (rstn),
    .en_i   (state_q == ST_SHIFT),
    .sclk_o (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = legal ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (sclk_fall && bit_cnt_q == LAST_BIT) state_d = ST_GAP;
      ST_GAP:   if (gap_cnt_q == 8'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = 1'b1;
    serial_in = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = rdy_q;
        busy      = 1'b0;
      end
      ST_SHIFT: serial_in = tx_q[FRAME_BITS-1];
      ST_GAP:   serial_in = 1'b0;
      ST_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: busy = 1'b0;
    endcase
  end

  // Gap counter is loaded at acceptance and untouched during SHIFT, so it
  // is ready the moment GAP is entered. The bit counter saturates rather
  // than wraps so a stuck strobe can never restart the frame.
  always_comb begin
    tx_d      = tx_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    err_d     = err_q;
    if (accept) begin
      tx_d      = {bus.req_addr, bus.req_wdata};
      bit_cnt_d = '0;
      gap_cnt_d = GAP_LOAD;
      err_d     = !legal;
    end else if (state_q == ST_SHIFT && sclk_fall) begin
      tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
      if (!(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + 5'd1;
    end else if (state_q == ST_GAP && gap_cnt_q != 8'd0) begin
      gap_cnt_d = gap_cnt_q - 8'd1;
    end
  end

  // rdy_q holds req_ready low until the first edge after reset release.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      tx_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_d;
      rdy_q     <= 1'b1;
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Only the last DATA_W samples reach rdata, so the receive shifter is
  // no wider than that.
  always_comb begin
    rx_d    = rx_q;
    rdata_d = rdata_q;
    if (state_q == ST_SHIFT && sclk_rise) rx_d = {rx_q[DATA_W-2:0], serial_out};
    if (state_q == ST_GAP && state_d == ST_DONE) rdata_d = rx_q;
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
`else
  logic [1:0] unused_readback;
  assign unused_readback = {serial_out, sclk_rise};
  assign bus.rdata       = '0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.busy      = busy;

endmodule
